// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Responder side of the req/ready memory handshake for the stage12 and stage3
// pipeline ports. Both ports share one single-port synchronous RAM with a
// one-cycle read latency. The arbiter serves one access at a time through a
// three-state FSM (IDLE -> ACCESS -> RESP). All port and RAM outputs are
// registered.
//
// Optional feature, enabled by defining RAM_ARB_ROUND_ROBIN_EN:
//   When both ports are eligible on the same cycle, grant the port that was
//   not granted last (round robin). When the macro is undefined, stage12
//   always wins ties (fixed priority).
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  ram_clk,
    input  logic                  rst,

    input  logic                  stage12_req,
    input  logic                  stage12_write,
    input  logic [ADDR_WIDTH-1:0] stage12_address,
    input  logic [DATA_WIDTH-1:0] stage12_data_in,
    output logic                  stage12_ready,
    output logic [DATA_WIDTH-1:0] stage12_data_out,

    input  logic                  stage3_req,
    input  logic                  stage3_write,
    input  logic [ADDR_WIDTH-1:0] stage3_address,
    input  logic [DATA_WIDTH-1:0] stage3_data_in,
    output logic                  stage3_ready,
    output logic [DATA_WIDTH-1:0] stage3_data_out,

    output logic                  ram_write_enable,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;

    // A port may only be accepted again after it has been seen with req low,
    // so a request left high after its ready pulse is not served twice.
    logic armed12;
    logic armed3;

    // Port currently being served (1 = stage3) and whether it is a write.
    logic cur_is3;
    logic cur_write;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // Port granted most recently (1 = stage3); used only to break ties.
    logic last_grant;
`endif

    logic                  elig12;
    logic                  elig3;
    logic                  grant_any;
    logic                  grant3;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_address;
    logic [DATA_WIDTH-1:0] sel_data;

    assign elig12    = stage12_req & armed12;
    assign elig3     = stage3_req & armed3;
    assign grant_any = elig12 | elig3;

    // Pick the port to grant this cycle; only ties need a policy.
    always_comb begin
        grant3 = elig3 & ~elig12;
        if (elig12 && elig3) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
            grant3 = ~last_grant;
`else
            grant3 = 1'b0;
`endif
        end
    end

    assign sel_write   = grant3 ? stage3_write   : stage12_write;
    assign sel_address = grant3 ? stage3_address : stage12_address;
    assign sel_data    = grant3 ? stage3_data_in : stage12_data_in;

    // Arbitration FSM driving registered RAM controls, port responses and armed flags.
    always_ff @(posedge ram_clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            stage12_ready    <= 1'b0;
            stage3_ready     <= 1'b0;
            stage12_data_out <= '0;
            stage3_data_out  <= '0;
            ram_write_enable <= 1'b0;
            ram_address      <= '0;
            ram_data_in      <= '0;
            armed12          <= 1'b1;
            armed3           <= 1'b1;
            cur_is3          <= 1'b0;
            cur_write        <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_grant       <= 1'b1;
`endif
        end else begin
            // Ready is a single-cycle pulse; it is only raised in RESP.
            stage12_ready <= 1'b0;
            stage3_ready  <= 1'b0;

            // Any cycle with req low re-arms the port for its next request.
            if (!stage12_req) armed12 <= 1'b1;
            if (!stage3_req)  armed3  <= 1'b1;

            case (state)
                IDLE: begin
                    if (grant_any) begin
                        ram_address      <= sel_address;
                        ram_data_in      <= sel_data;
                        ram_write_enable <= sel_write;
                        cur_is3          <= grant3;
                        cur_write        <= sel_write;
                        if (grant3) armed3  <= 1'b0;
                        else        armed12 <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
                        last_grant       <= grant3;
`endif
                        state            <= ACCESS;
                    end
                end

                ACCESS: begin
                    // The RAM samples address/we on this edge; drop we so the
                    // write lands exactly once.
                    ram_write_enable <= 1'b0;
                    state            <= RESP;
                end

                RESP: begin
                    // Read data is valid now; writes leave data_out untouched.
                    if (cur_is3) begin
                        stage3_ready <= 1'b1;
                        if (!cur_write) stage3_data_out <= ram_data_out;
                    end else begin
                        stage12_ready <= 1'b1;
                        if (!cur_write) stage12_data_out <= ram_data_out;
                    end
                    state <= IDLE;
                end

                default: begin
                    ram_write_enable <= 1'b0;
                    state            <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Self-checking bench for ram_port_arbiter. A behavioural RAM sits on the RAM
// side; a reference memory model predicts each port's data_out and pushes it
// into a per-port scoreboard queue when a request is issued. A monitor pops
// and compares on every ready pulse.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        stage12_req = 1'b0;
    logic        stage12_write = 1'b0;
    logic [15:0] stage12_address = '0;
    logic [7:0]  stage12_data_in = '0;
    logic        stage12_ready;
    logic [7:0]  stage12_data_out;

    logic        stage3_req = 1'b0;
    logic        stage3_write = 1'b0;
    logic [15:0] stage3_address = '0;
    logic [7:0]  stage3_data_in = '0;
    logic        stage3_ready;
    logic [7:0]  stage3_data_out;

    logic        ram_write_enable;
    logic [15:0] ram_address;
    logic [7:0]  ram_data_in;
    logic [7:0]  ram_data_out = '0;

    ram_port_arbiter #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(8)
    ) dut (
        .ram_clk         (clk),
        .rst             (rst),
        .stage12_req     (stage12_req),
        .stage12_write   (stage12_write),
        .stage12_address (stage12_address),
        .stage12_data_in (stage12_data_in),
        .stage12_ready   (stage12_ready),
        .stage12_data_out(stage12_data_out),
        .stage3_req      (stage3_req),
        .stage3_write    (stage3_write),
        .stage3_address  (stage3_address),
        .stage3_data_in  (stage3_data_in),
        .stage3_ready    (stage3_ready),
        .stage3_data_out (stage3_data_out),
        .ram_write_enable(ram_write_enable),
        .ram_address     (ram_address),
        .ram_data_in     (ram_data_in),
        .ram_data_out    (ram_data_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_rdy12 = 0;
    int n_rdy3 = 0;
    int n_we = 0;
    int rcyc12 = 0;
    int rcyc3 = 0;
    int writes_issued = 0;

    logic [7:0] ram_aa [int];
    logic [7:0] ref_aa [int];
    logic [7:0] q12 [$];
    logic [7:0] q3 [$];
    logic [7:0] last12 = 8'h00;
    logic [7:0] last3 = 8'h00;

    function automatic logic [7:0] init_val(input int a);
        if (a == 4) return 8'h01;
        return 8'(a * 13 + (a >> 8) + 5);
    endfunction

    function automatic logic [7:0] ram_peek(input int a);
        return ram_aa.exists(a) ? ram_aa[a] : init_val(a);
    endfunction

    function automatic logic [7:0] ref_read(input int a);
        return ref_aa.exists(a) ? ref_aa[a] : init_val(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Cycle counter, bumped on every rising edge.
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Synchronous single-port RAM with one-cycle read latency.
    initial forever begin
        logic [7:0] rd;
        @(posedge clk);
        rd = ram_peek(int'(ram_address));
        if (ram_write_enable) ram_aa[int'(ram_address)] = ram_data_in;
        ram_data_out <= rd;
    end

    // Monitor: sampled on the falling edge, pops the scoreboard on each ready.
    initial begin
        logic prev12;
        logic prev3;
        logic [7:0] e;
        prev12 = 1'b0;
        prev3 = 1'b0;
        forever begin
            @(negedge clk);
            if (ram_write_enable) n_we++;
            if (stage12_ready) begin
                n_rdy12++;
                rcyc12 = cyc;
                check("ready12_width", 32'(prev12), 32'd0);
                if (q12.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready12 got ready with no request outstanding at cycle %0d", cyc);
                end else begin
                    e = q12.pop_front();
                    check("data_out12", 32'(stage12_data_out), 32'(e));
                end
            end
            if (stage3_ready) begin
                n_rdy3++;
                rcyc3 = cyc;
                check("ready3_width", 32'(prev3), 32'd0);
                if (q3.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready3 got ready with no request outstanding at cycle %0d", cyc);
                end else begin
                    e = q3.pop_front();
                    check("data_out3", 32'(stage3_data_out), 32'(e));
                end
            end
            prev12 = stage12_ready;
            prev3 = stage3_ready;
        end
    end

    task automatic drive(input int p, input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
        if (p == 12) begin
            stage12_req = r; stage12_write = w; stage12_address = a; stage12_data_in = d;
        end else begin
            stage3_req = r; stage3_write = w; stage3_address = a; stage3_data_in = d;
        end
    endtask

    // Issue one request, wait for its ready, hold req for extra cycles, then drop req for one cycle.
    task automatic issue(input int p, input logic w, input logic [15:0] a, input logic [7:0] d, input int hold);
        logic [7:0] e;
        bit ok;
        if (w) begin
            ref_aa[int'(a)] = d;
            e = (p == 12) ? last12 : last3;
            writes_issued++;
        end else begin
            e = ref_read(int'(a));
            if (p == 12) last12 = e; else last3 = e;
        end
        if (p == 12) q12.push_back(e); else q3.push_back(e);
        drive(p, 1'b1, w, a, d);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if ((p == 12) ? stage12_ready : stage3_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL timeout_port%0d got no ready within 60 cycles, required one", p);
        end
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        drive(p, 1'b0, w, a, d);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_ready12", 32'(stage12_ready), 32'd0);
        check("rst_ready3", 32'(stage3_ready), 32'd0);
        check("rst_data_out12", 32'(stage12_data_out), 32'd0);
        check("rst_data_out3", 32'(stage3_data_out), 32'd0);
        check("rst_ram_we", 32'(ram_write_enable), 32'd0);
        check("rst_ram_address", 32'(ram_address), 32'd0);
        check("rst_ram_data_in", 32'(ram_data_in), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int we0;
        int rd0;
        int prc;
        int wr0;
        logic first3_exp;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Test 1: stage12 read of address 4, latency and no write
        c0 = cyc;
        we0 = n_we;
        issue(12, 1'b0, 16'h0004, 8'h00, 0);
        check("t1_latency", rcyc12 - c0, 3);
        check("t1_no_write", n_we - we0, 0);
        check("t1_data_held", 32'(stage12_data_out), 32'h01);

        // Test 2: stage3 read, write, read back
        issue(3, 1'b0, 16'h1235, 8'h00, 0);
        we0 = n_we;
        issue(3, 1'b1, 16'h1234, 8'hA5, 0);
        check("t2_one_write", n_we - we0, 1);
        check("t2_ram_content", 32'(ram_peek(32'h1234)), 32'hA5);
        issue(3, 1'b0, 16'h1234, 8'h00, 0);
        check("t2_readback", 32'(stage3_data_out), 32'hA5);

        // Test 3: simultaneous requests, then a tie after a lone stage12 grant
        fork
            issue(12, 1'b0, 16'h0000, 8'h00, 0);
            issue(3, 1'b0, 16'h0010, 8'h00, 0);
        join
        check("t3a_order_gap", rcyc3 - rcyc12, 3);
        issue(12, 1'b0, 16'h0001, 8'h00, 0);
        fork
            issue(12, 1'b0, 16'h0000, 8'h00, 0);
            issue(3, 1'b0, 16'h0010, 8'h00, 0);
        join
`ifdef RAM_ARB_ROUND_ROBIN_EN
        first3_exp = 1'b1;
`else
        first3_exp = 1'b0;
`endif
        check("t3b_stage3_first", 32'(rcyc3 < rcyc12), 32'(first3_exp));
        check("t3b_gap", (rcyc3 > rcyc12) ? rcyc3 - rcyc12 : rcyc12 - rcyc3, 3);

        // Test 4: req held long after ready gives one access
        rd0 = n_rdy12;
        issue(12, 1'b0, 16'h0007, 8'h00, 10);
        repeat (4) @(posedge clk);
        #1;
        check("t4_one_ready", n_rdy12 - rd0, 1);

        // Test 6: back-to-back reads at the minimum period
        prc = 0;
        for (int k = 0; k < 4; k++) begin
            issue(12, 1'b0, 16'(k), 8'h00, 0);
            if (k > 0) check("t6_period", rcyc12 - prc, 4);
            prc = rcyc12;
        end

        // Test 5: reset during a stage3 access with stage12 waiting
        rd0 = n_rdy3;
        drive(3, 1'b1, 1'b0, 16'h0040, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(3, 1'b0, 1'b0, 16'h0040, 8'h00);
        last12 = 8'h00;
        last3 = 8'h00;
        #1;
        check_reset_values();
        fork
            issue(12, 1'b0, 16'h0050, 8'h00, 0);
            begin
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
                rst = 1'b0;
            end
        join
        check("t5_no_stage3_ready", n_rdy3 - rd0, 0);

        // Randomized traffic on disjoint address windows
        wr0 = writes_issued;
        we0 = n_we;
        fork
            for (int i = 0; i < 30; i++) begin
                issue(12, 1'($urandom_range(0, 1)), {12'h000, 4'($urandom)}, 8'($urandom), $urandom_range(0, 2));
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            for (int j = 0; j < 30; j++) begin
                issue(3, 1'($urandom_range(0, 1)), {12'h800, 4'($urandom)}, 8'($urandom), $urandom_range(0, 2));
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("rand_write_count", n_we - we0, writes_issued - wr0);
        check("q12_drained", q12.size(), 0);
        check("q3_drained", q3.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
